led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_led_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: an Avalon-MM configured table of LED patterns
// is played out to a PIO slave, one single-cycle write per step, with a
// programmable spacing between strobes, optional looping and a done interrupt.
module led_sequencer #(
  parameter int LED_WIDTH = 10,
  parameter int NUM_STEPS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t               state;
  logic                 run;
  logic                 loop;
  logic                 irq_en;
  logic                 done;
  logic [31:0]          period;
  logic [4:0]           steps;
  logic [IDX_W-1:0]     index;
  logic [31:0]          wait_cnt;
  logic [LED_WIDTH-1:0] pattern_mem [NUM_STEPS];

  // Slave write decode
  logic             wr_en;
  logic             ctrl_wr;
  logic             status_wr;
  logic             period_wr;
  logic             steps_wr;
  logic             pattern_wr;
  logic [IDX_W-1:0] pattern_sel;

  assign wr_en       = chipselect & ~write_n;
  assign ctrl_wr     = wr_en && (address == 5'd0);
  assign status_wr   = wr_en && (address == 5'd1);
  assign period_wr   = wr_en && (address == 5'd2);
  assign steps_wr    = wr_en && (address == 5'd3);
  assign pattern_wr  = wr_en && address[4] && ({1'b0, address[3:0]} < 5'(NUM_STEPS));
  assign pattern_sel = address[IDX_W-1:0];

  // Effective period (0 and 1 behave as 2) and index of the last step
  // after clamping STEPS into 1..NUM_STEPS.
  logic [31:0]      period_eff;
  logic [4:0]       last5;
  logic [IDX_W-1:0] last_index;
  logic             at_last;
  logic [IDX_W-1:0] index_inc;
  logic             start;
  logic             stop;

  assign period_eff = (period < 32'd2) ? 32'd2 : period;
  assign last5      = (steps == 5'd0)            ? 5'd0 :
                      (steps > 5'(NUM_STEPS))    ? 5'(NUM_STEPS - 1) :
                                                   steps - 5'd1;
  assign last_index = last5[IDX_W-1:0];
  // >= so that shrinking STEPS mid-run below the current index still ends the pass
  assign at_last    = (index >= last_index);
  assign index_inc  = index + 1'b1;
  assign start      = ctrl_wr && writedata[0] && (state == IDLE);
  assign stop       = ctrl_wr && !writedata[0] && (state != IDLE);

  function automatic logic [31:0] zext(input logic [LED_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[LED_WIDTH-1:0] = v;
    return r;
  endfunction

  // Configuration registers and pattern table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      steps  <= '0;
      for (int i = 0; i < NUM_STEPS; i++) pattern_mem[i] <= '0;
    end else begin
      if (period_wr) period <= writedata;
      if (steps_wr)  steps  <= writedata[4:0];
      if (pattern_wr) pattern_mem[pattern_sel] <= writedata[LED_WIDTH-1:0];
    end
  end

  // Sequencer FSM with control/status bits and registered PIO outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      run            <= 1'b0;
      loop           <= 1'b0;
      irq_en         <= 1'b0;
      done           <= 1'b0;
      index          <= '0;
      wait_cnt       <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;

      if (ctrl_wr) begin
        loop   <= writedata[1];
        irq_en <= writedata[2];
        // A run=1 write while busy must not restart; only clearing matters then.
        if (state == IDLE)     run <= writedata[0];
        else if (!writedata[0]) run <= 1'b0;
      end

      // Clear first so a completion on the same edge overrides it.
      if (status_wr && writedata[1]) done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            done           <= 1'b0;
            index          <= '0;
            state          <= STROBE;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= zext(pattern_mem[0]);
          end
        end
        STROBE: begin
          // Count covers the strobe cycle itself plus the expiry edge.
          wait_cnt <= period_eff - 32'd2;
          state    <= stop ? IDLE : WAIT;
        end
        WAIT: begin
          if (stop) begin
            state <= IDLE;
          end else if (wait_cnt == 32'd0) begin
            if (!at_last) begin
              index          <= index_inc;
              state          <= STROBE;
              pio_chipselect <= 1'b1;
              pio_write_n    <= 1'b0;
              pio_writedata  <= zext(pattern_mem[index_inc]);
            end else if (loop) begin
              index          <= '0;
              state          <= STROBE;
              pio_chipselect <= 1'b1;
              pio_write_n    <= 1'b0;
              pio_writedata  <= zext(pattern_mem[0]);
            end else begin
              done  <= 1'b1;
              run   <= 1'b0;
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pio_address = 2'd0;
  assign irq         = done & irq_en;

  // Zero-latency register read mux
  always_comb begin
    readdata = '0;
    case (address)
      5'd0: readdata[2:0] = {irq_en, loop, run};
      5'd1: begin
        readdata[0]   = (state != IDLE);
        readdata[1]   = done;
        readdata[7:4] = 4'(index);
      end
      5'd2: readdata = period;
      5'd3: readdata[4:0] = steps;
      default: begin
        if (address[4] && ({1'b0, address[3:0]} < 5'(NUM_STEPS)))
          readdata[LED_WIDTH-1:0] = pattern_mem[pattern_sel];
      end
    endcase
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: expected strobes (cycle, data) are derived
// arithmetically from the programmed table/PERIOD/STEPS and queued; a
// monitor pops and compares every strobe the DUT presents.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        irq;

  led_sequencer #(.LED_WIDTH(10), .NUM_STEPS(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] d;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (pio_chipselect === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%h required=none (cycle %0d)", pio_writedata, cyc);
        end else begin
          e = sb.pop_front();
          chk("strobe_time", cyc, e.t);
          chk("strobe_data", pio_writedata, e.d);
          chk("strobe_write_n", {31'b0, pio_write_n}, 32'd0);
          $display("strobe cycle=%0d data=%h", cyc, pio_writedata);
        end
      end else begin
        chk("idle_pio", {pio_write_n, pio_address, pio_writedata[28:0]}, 32'h8000_0000);
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic load_cfg(input int per, input int stp, input bit fixed);
    for (int i = 0; i < 8; i++) begin
      tbl[i] = 10'($urandom);
      if (fixed && i == 0) tbl[i] = 10'h001;
      if (fixed && i == 1) tbl[i] = 10'h002;
      if (fixed && i == 2) tbl[i] = 10'h3FF;
      wr(5'(16 + i), {$urandom} & 32'hFFFF_FC00 | {22'b0, tbl[i]});
    end
    wr(5'd2, per);
    wr(5'd3, stp);
  endtask

  function automatic int eff_p(input int per);
    return (per < 2) ? 2 : per;
  endfunction

  function automatic int eff_s(input int stp);
    return (stp == 0) ? 1 : ((stp > 8) ? 8 : stp);
  endfunction

  task automatic run_single(input int per, input int stp, input bit ie, input bit fixed);
    int P, S, w;
    logic [31:0] v;
    P = eff_p(per);
    S = eff_s(stp);
    load_cfg(per, stp, fixed);
    w = cyc;
    for (int k = 0; k < S; k++) sb.push_back('{w + 1 + k * P, {22'b0, tbl[k]}});
    wr(5'd0, {29'b0, ie, 1'b0, 1'b1});
    repeat (S * P - 1) @(negedge clk);
    rd(5'd1, v);
    chk("status_before_done", v, 32'((S - 1) << 4) | 32'h1);
    @(negedge clk);
    rd(5'd1, v);
    chk("status_done", v, 32'((S - 1) << 4) | 32'h2);
    rd(5'd0, v);
    chk("ctrl_after_done", v, {29'b0, ie, 2'b00});
    chk("irq_after_done", {31'b0, irq}, {31'b0, ie});
    chk("scoreboard_empty", sb.size(), 0);
    $display("single per=%0d steps=%0d irq_en=%0d", per, stp, ie);
    if (ie) wr(5'd1, 32'h2);
  endtask

  task automatic run_loop_cancel(input int per, input int stp, input int ncyc);
    int P, S, w, c, lastk;
    logic [31:0] v;
    P = eff_p(per);
    S = eff_s(stp);
    load_cfg(per, stp, 1'b0);
    w = cyc;
    c = w + 1 + ncyc;
    lastk = 0;
    for (int k = 0; w + 1 + k * P <= c; k++) begin
      sb.push_back('{w + 1 + k * P, {22'b0, tbl[k % S]}});
      lastk = k;
    end
    wr(5'd0, 32'h3);
    while (cyc < c) @(negedge clk);
    wr(5'd0, 32'h0);
    repeat (P + 4) @(negedge clk);
    rd(5'd1, v);
    chk("status_after_cancel", v, 32'((lastk % S) << 4));
    rd(5'd0, v);
    chk("ctrl_after_cancel", v, 32'h0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("loop per=%0d steps=%0d cancel_after=%0d strobes=%0d", per, stp, ncyc, lastk + 1);
  endtask

  initial begin
    logic [31:0] v;
    int w;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    chk("reset_pio_cs", {31'b0, pio_chipselect}, 32'd0);
    chk("reset_pio_wn", {31'b0, pio_write_n}, 32'd1);
    chk("reset_pio_data", pio_writedata, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    rd(5'd0, v); chk("reset_ctrl", v, 32'd0);
    rd(5'd1, v); chk("reset_status", v, 32'd0);
    rd(5'd2, v); chk("reset_period", v, 32'd0);
    rd(5'd16, v); chk("reset_table0", v, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Register map readback and unmapped addresses
    wr(5'd2, 32'hDEAD_BEEF);
    rd(5'd2, v); chk("period_rb", v, 32'hDEAD_BEEF);
    wr(5'd3, 32'hFFFF_FFF5);
    rd(5'd3, v); chk("steps_rb", v, 32'h15);
    wr(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, v); chk("unmapped5", v, 32'd0);
    wr(5'd24, 32'hFFFF_FFFF);
    rd(5'd24, v); chk("unmapped24", v, 32'd0);
    address = 5'd3; writedata = 32'h7; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk); write_n = 1'b1;
    rd(5'd3, v); chk("no_cs_write", v, 32'h15);

    // Directed: single pass, clamps
    run_single(4, 3, 1'b0, 1'b1);
    run_single(0, 0, 1'b0, 1'b0);
    run_single(4, 20, 1'b0, 1'b0);
    run_single(1, 8, 1'b1, 1'b0);

    // Directed loop + cancel
    run_loop_cancel(3, 2, 17);
    run_loop_cancel(3, 2, 18);

    // irq: set and clear on the same edge -> stays set, then clear
    load_cfg(2, 1, 1'b0);
    w = cyc;
    sb.push_back('{w + 1, {22'b0, tbl[0]}});
    wr(5'd0, 32'h5);
    @(negedge clk);
    wr(5'd1, 32'h2);
    rd(5'd1, v); chk("done_set_wins", v, 32'h2);
    chk("irq_set", {31'b0, irq}, 32'd1);
    wr(5'd1, 32'h2);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rd(5'd1, v); chk("done_cleared", v, 32'h0);
    $display("irq set/clear done");

    // Randomized passes and loop cancels
    for (int i = 0; i < 6; i++)
      run_single($urandom_range(0, 6), $urandom_range(0, 20), 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++)
      run_loop_cancel($urandom_range(0, 5), $urandom_range(0, 20), $urandom_range(0, 30));

    // Reset in the middle of WAIT
    load_cfg(5, 3, 1'b0);
    w = cyc;
    sb.push_back('{w + 1, {22'b0, tbl[0]}});
    wr(5'd0, 32'h7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_pio_cs", {31'b0, pio_chipselect}, 32'd0);
    chk("midreset_pio_wn", {31'b0, pio_write_n}, 32'd1);
    chk("midreset_pio_data", pio_writedata, 32'd0);
    rd(5'd0, v); chk("midreset_ctrl", v, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    rd(5'd1, v); chk("post_reset_status", v, 32'd0);
    rd(5'd17, v); chk("post_reset_table1", v, 32'd0);
    $display("reset mid-wait done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
